// File: rtl/avg_stat_pkg.sv
// Shared types and fixed-point constants for the averaging statistics front end.
//   state_e          : control FSM states
//   DATA_W / FRAC    : sfix16_En4 sample format
//   PROD_W           : width of a full sfix16 x sfix16 product (sfix32_En8)
//   SAT_MAX/SAT_MIN  : 16-bit clip limits for the product averages
package avg_stat_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StAccum,
    StDrain,
    StLatch
  } state_e;

  localparam int unsigned DATA_W = 16;
  localparam int unsigned FRAC   = 4;
  localparam int unsigned PROD_W = 32;

  localparam logic [DATA_W-1:0] SAT_MAX = 16'h7FFF;
  localparam logic [DATA_W-1:0] SAT_MIN = 16'h8000;

endpackage

// File: rtl/avg_lane.sv
// One statistics lane: a signed accumulator with synchronous clear/enable and the
// shift/saturate that turns the sum into an sfix16_En4 average.
//   clk_i  : clock
//   rst_i  : synchronous active-high reset, clears the accumulator
//   clr_i  : clear accumulator (start of a burst)
//   en_i   : add din_i into the accumulator
//   din_i  : signed input term, InW bits
//   avg_o  : (sum >>> (Log2N + FracShift)) clipped to 16 bits
module avg_lane
  import avg_stat_pkg::*;
#(
  parameter int unsigned InW       = 16,
  parameter int unsigned Log2N     = 4,
  parameter int unsigned FracShift = 0
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    clr_i,
  input  logic                    en_i,
  input  logic signed [InW-1:0]   din_i,
  output logic        [DATA_W-1:0] avg_o
);

  // Log2N guard bits make overflow impossible for a burst of 2^Log2N terms.
  localparam int unsigned AccW  = InW + Log2N;
  localparam int unsigned Shift = Log2N + FracShift;

  logic signed [AccW-1:0] acc_q, acc_d;
  logic signed [AccW-1:0] shifted;
  logic        [AccW-DATA_W:0] upper;

  always_comb begin
    acc_d = acc_q;
    if (clr_i) begin
      acc_d = '0;
    end else if (en_i) begin
      acc_d = acc_q + AccW'(din_i);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

  // Arithmetic shift floors toward minus infinity.
  assign shifted = acc_q >>> Shift;
  // The value fits in 16 bits exactly when bit 15 and everything above agree.
  assign upper   = shifted[AccW-1:DATA_W-1];

  always_comb begin
    avg_o = shifted[DATA_W-1:0];
    if (!((&upper) || !(|upper))) begin
      avg_o = shifted[AccW-1] ? SAT_MIN : SAT_MAX;
    end
  end

endmodule

// File: rtl/avg_stat_gen.sv
// Streaming statistics front end: accepts a burst of 2^LOG2_N (x, y) samples in
// sfix16_En4, accumulates sum x, y, x^2, y^2, x*y and presents the five averages
// with a one-cycle avg_valid_out strobe.
//   clk, rst               : clock, synchronous active-high reset
//   start                  : arms a burst when idle
//   busy                   : FSM not idle
//   sample_valid/ready     : sample handshake on x_in / y_in
//   x_avg, y_avg           : sfix16_En4 averages of x and y
//   x_sqr_avg, y_sqr_avg,
//   x_mul_y_avg            : saturated sfix16_En4 averages of x^2, y^2, x*y
//   avg_valid_out          : one-cycle strobe, all five averages valid
module avg_stat_gen
  import avg_stat_pkg::*;
#(
  parameter int unsigned LOG2_N = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              busy,
  input  logic              sample_valid,
  output logic              sample_ready,
  input  logic [DATA_W-1:0] x_in,
  input  logic [DATA_W-1:0] y_in,
  output logic [DATA_W-1:0] x_avg,
  output logic [DATA_W-1:0] y_avg,
  output logic [DATA_W-1:0] x_sqr_avg,
  output logic [DATA_W-1:0] y_sqr_avg,
  output logic [DATA_W-1:0] x_mul_y_avg,
  output logic              avg_valid_out
);

  state_e            state_q, state_d;
  logic              drain_q, drain_d;
  logic [LOG2_N-1:0] cnt_q, cnt_d;

  logic accept;
  logic clr;
  logic latch;

  // Stage 1: registered inputs.
  logic                     s1_valid_q;
  logic signed [DATA_W-1:0] x1_q, y1_q;
  // Stage 2: products plus passthrough.
  logic                     s2_valid_q;
  logic signed [DATA_W-1:0] x2_q, y2_q;
  logic signed [PROD_W-1:0] xx2_q, yy2_q, xy2_q;
  logic signed [PROD_W-1:0] xx_prod, yy_prod, xy_prod;

  logic [DATA_W-1:0] x_lane, y_lane, xx_lane, yy_lane, xy_lane;
  logic [DATA_W-1:0] x_avg_q, y_avg_q, xx_avg_q, yy_avg_q, xy_avg_q;
  logic              avg_valid_q;

  assign busy         = (state_q != StIdle);
  assign sample_ready = (state_q == StAccum);
  assign accept       = sample_valid && sample_ready;
  assign clr          = (state_q == StIdle) && start;
  assign latch        = (state_q == StLatch);

  // ---------------------------------------------------------------------------
  // Control FSM
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    drain_d = 1'b0;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d = StAccum;
          cnt_d   = '0;
        end
      end
      StAccum: begin
        if (accept) begin
          cnt_d = cnt_q + 1'b1;
          // Counter at all-ones means this is sample N-1.
          if (&cnt_q) begin
            state_d = StDrain;
          end
        end
      end
      StDrain: begin
        // Two cycles: let the last sample pass stages 2 and 3.
        drain_d = ~drain_q;
        if (drain_q) begin
          state_d = StLatch;
        end
      end
      StLatch: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      drain_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      drain_q <= drain_d;
      cnt_q   <= cnt_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Input / product pipeline
  // ---------------------------------------------------------------------------
  assign xx_prod = PROD_W'(x1_q) * PROD_W'(x1_q);
  assign yy_prod = PROD_W'(y1_q) * PROD_W'(y1_q);
  assign xy_prod = PROD_W'(x1_q) * PROD_W'(y1_q);

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s2_valid_q <= 1'b0;
    end else begin
      s1_valid_q <= accept;
      s2_valid_q <= s1_valid_q;
    end
  end

  // Data registers need no reset; the valid bits qualify them.
  always_ff @(posedge clk) begin
    if (accept) begin
      x1_q <= x_in;
      y1_q <= y_in;
    end
    if (s1_valid_q) begin
      x2_q  <= x1_q;
      y2_q  <= y1_q;
      xx2_q <= xx_prod;
      yy2_q <= yy_prod;
      xy2_q <= xy_prod;
    end
  end

  // ---------------------------------------------------------------------------
  // Accumulator lanes
  // ---------------------------------------------------------------------------
  avg_lane #(
    .InW      (DATA_W),
    .Log2N    (LOG2_N),
    .FracShift(0)
  ) u_lane_x (
    .clk_i(clk),
    .rst_i(rst),
    .clr_i(clr),
    .en_i (s2_valid_q),
    .din_i(x2_q),
    .avg_o(x_lane)
  );

  avg_lane #(
    .InW      (DATA_W),
    .Log2N    (LOG2_N),
    .FracShift(0)
  ) u_lane_y (
    .clk_i(clk),
    .rst_i(rst),
    .clr_i(clr),
    .en_i (s2_valid_q),
    .din_i(y2_q),
    .avg_o(y_lane)
  );

  // Products are En8; the extra FRAC shift brings them back to En4.
  avg_lane #(
    .InW      (PROD_W),
    .Log2N    (LOG2_N),
    .FracShift(FRAC)
  ) u_lane_xx (
    .clk_i(clk),
    .rst_i(rst),
    .clr_i(clr),
    .en_i (s2_valid_q),
    .din_i(xx2_q),
    .avg_o(xx_lane)
  );

  avg_lane #(
    .InW      (PROD_W),
    .Log2N    (LOG2_N),
    .FracShift(FRAC)
  ) u_lane_yy (
    .clk_i(clk),
    .rst_i(rst),
    .clr_i(clr),
    .en_i (s2_valid_q),
    .din_i(yy2_q),
    .avg_o(yy_lane)
  );

  avg_lane #(
    .InW      (PROD_W),
    .Log2N    (LOG2_N),
    .FracShift(FRAC)
  ) u_lane_xy (
    .clk_i(clk),
    .rst_i(rst),
    .clr_i(clr),
    .en_i (s2_valid_q),
    .din_i(xy2_q),
    .avg_o(xy_lane)
  );

  // ---------------------------------------------------------------------------
  // Output registers: hold until the next LATCH
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      x_avg_q     <= '0;
      y_avg_q     <= '0;
      xx_avg_q    <= '0;
      yy_avg_q    <= '0;
      xy_avg_q    <= '0;
      avg_valid_q <= 1'b0;
    end else begin
      avg_valid_q <= latch;
      if (latch) begin
        x_avg_q  <= x_lane;
        y_avg_q  <= y_lane;
        xx_avg_q <= xx_lane;
        yy_avg_q <= yy_lane;
        xy_avg_q <= xy_lane;
      end
    end
  end

  assign x_avg         = x_avg_q;
  assign y_avg         = y_avg_q;
  assign x_sqr_avg     = xx_avg_q;
  assign y_sqr_avg     = yy_avg_q;
  assign x_mul_y_avg   = xy_avg_q;
  assign avg_valid_out = avg_valid_q;

endmodule
